// File: rtl/holo_pkg.sv
// Shared types and defaults for the phase frame scheduling path.
// Command codes are the bytes the FT host sends ahead of each transaction.
package holo_pkg;

    typedef logic [7:0] phase_t;

    typedef enum logic [7:0] {
        CMD_PHASES  = 8'h01,
        CMD_ENABLE  = 8'h02,
        CMD_DISABLE = 8'h03,
        CMD_CLR_ERR = 8'h04
    } cmd_e;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOAD    = 2'd1,
        PENDING = 2'd2
    } sched_state_e;

    localparam int PERIOD_CYCLES_DEFAULT = 1250;
    localparam int NUM_CHANNELS_DEFAULT  = 4;

endpackage

// File: rtl/sync_edge_detect.sv
// Two-flop synchroniser for an asynchronous level, followed by a rising-edge
// pulse. The pulse comes from the third (detection) register.
module sync_edge_detect (
    input  logic sys_clk,
    input  logic rst_n,
    input  logic async_in,
    output logic rise
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= async_in;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign rise = sync_q & ~prev_q;

endmodule

// File: rtl/phase_frame_scheduler.sv
// Double-buffers phase frames from the FT receiver and commits them to the
// channel drivers only on emission-period boundaries (wrap or slave sync).
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   IDLE    | waiting for a command byte
//   LOAD    | collecting NUM_CHANNELS phase bytes into the shadow buffer
//   PENDING | full frame in shadow, waiting for the next commit event
module phase_frame_scheduler
    import holo_pkg::*;
#(
    parameter int NUM_CHANNELS  = NUM_CHANNELS_DEFAULT,
    parameter int PERIOD_CYCLES = PERIOD_CYCLES_DEFAULT,
    parameter int SYNC_MASTER   = 1
) (
    input  logic                      sys_clk,
    input  logic                      rst_n,
    input  logic [7:0]                rx_data,
    input  logic                      rx_valid,
    output logic                      rx_ready,
    input  logic                      sync_in,
    output logic                      sync_out,
    output logic [8*NUM_CHANNELS-1:0] phases_out,
    output logic                      out_enable,
    output logic                      period_start,
    output logic                      frame_error
);

    localparam int CW = (PERIOD_CYCLES > 1) ? $clog2(PERIOD_CYCLES) : 1;
    localparam int IW = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(PERIOD_CYCLES - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(NUM_CHANNELS - 1);

    sched_state_e  state_q;
    sched_state_e  state_d;
    logic [CW-1:0] cnt_q;
    logic [IW-1:0] idx_q;
    phase_t        shadow_q [NUM_CHANNELS];
    logic          sync_rise;
    logic          wrap;
    logic          commit_evt;
    logic          accept;

    sync_edge_detect u_sync_edge_detect (
        .sys_clk  (sys_clk),
        .rst_n    (rst_n),
        .async_in (sync_in),
        .rise     (sync_rise)
    );

    // A wrap and a sync edge in the same cycle collapse into one event.
    assign wrap       = (cnt_q == CNT_LAST);
    assign commit_evt = wrap || ((SYNC_MASTER == 0) && sync_rise);

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q        <= '0;
            period_start <= 1'b0;
        end else begin
            cnt_q        <= commit_evt ? '0 : cnt_q + 1'b1;
            period_start <= commit_evt;
        end
    end

    assign sync_out = (SYNC_MASTER != 0) ? period_start : 1'b0;

    assign rx_ready = (state_q != PENDING);
    assign accept   = rx_valid && rx_ready;

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept && (rx_data == CMD_PHASES)) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                if (accept && (idx_q == IDX_LAST)) begin
                    state_d = PENDING;
                end
            end
            PENDING: begin
                if (commit_evt) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A byte finishing the frame on a commit cycle lands in LOAD, so that
    // event is missed and the frame waits for the following one.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q       <= '0;
            phases_out  <= '0;
            out_enable  <= 1'b0;
            frame_error <= 1'b0;
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                shadow_q[i] <= '0;
            end
        end else begin
            if (accept) begin
                case (state_q)
                    IDLE: begin
                        case (rx_data)
                            CMD_PHASES:  idx_q       <= '0;
                            CMD_ENABLE:  out_enable  <= 1'b1;
                            CMD_DISABLE: out_enable  <= 1'b0;
                            CMD_CLR_ERR: frame_error <= 1'b0;
                            default:     frame_error <= 1'b1;
                        endcase
                    end
                    LOAD: begin
                        shadow_q[idx_q] <= rx_data;
                        idx_q           <= idx_q + 1'b1;
                    end
                    default: begin
                    end
                endcase
            end
            if ((state_q == PENDING) && commit_evt) begin
                for (int i = 0; i < NUM_CHANNELS; i++) begin
                    phases_out[8*i +: 8] <= shadow_q[i];
                end
            end
        end
    end

endmodule
